// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR sequencer: CSR addresses,
// mstatus bit positions, instruction op encoding and sequencer states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSR_RMW,
    ST_TRAP_MEPC,
    ST_TRAP_MCAUSE,
    ST_TRAP_MSTATUS,
    ST_TRAP_VECTOR,
    ST_MRET_MSTATUS,
    ST_MRET_EPC
  } state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/csr_sequencer_if.sv
// Requester and CSR-file signals of the sequencer; the sequencer uses the
// slave view, the pipeline/CSR-file side uses the master view.
interface csr_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     req_ready;
  logic                     csr_valid;
  logic [1:0]               csr_op;
  logic [ADDRESS_WIDTH-1:0] csr_address;
  logic [DATA_WIDTH-1:0]    csr_operand;
  logic                     csr_resp_valid;
  logic [DATA_WIDTH-1:0]    csr_rd_value;
  logic                     csr_illegal;
  logic                     trap_valid;
  logic                     trap_interrupt;
  logic [DATA_WIDTH-2:0]    trap_cause;
  logic [DATA_WIDTH-1:0]    trap_pc;
  logic                     mret_valid;
  logic                     redirect_valid;
  logic [DATA_WIDTH-1:0]    redirect_pc;
  logic [ADDRESS_WIDTH-1:0] file_address;
  logic [DATA_WIDTH-1:0]    file_read_value;
  logic [DATA_WIDTH-1:0]    file_write_value;
  logic                     file_write_enable;

  modport master (
    input  req_ready, csr_resp_valid, csr_rd_value, csr_illegal,
           redirect_valid, redirect_pc, file_address, file_write_value,
           file_write_enable,
    output csr_valid, csr_op, csr_address, csr_operand, trap_valid,
           trap_interrupt, trap_cause, trap_pc, mret_valid, file_read_value
  );

  modport slave (
    output req_ready, csr_resp_valid, csr_rd_value, csr_illegal,
           redirect_valid, redirect_pc, file_address, file_write_value,
           file_write_enable,
    input  csr_valid, csr_op, csr_address, csr_operand, trap_valid,
           trap_interrupt, trap_cause, trap_pc, mret_valid, file_read_value
  );
endinterface

// File: rtl/csr_rmw_alu.sv
// Combinational CSRRW/CSRRS/CSRRC new-value computation with write
// suppression (RS/RC with zero operand) and read-only address detection.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  csr_op_t               op,
  input  logic [1:0]            address_top,
  input  logic [DATA_WIDTH-1:0] old_value,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0] new_value,
  output logic                  write,
  output logic                  illegal
);
  logic suppress;
  logic read_only;

  always_comb begin
    new_value = old_value | operand;
    case (op)
      CSR_OP_RW: new_value = operand;
      CSR_OP_RC: new_value = old_value & ~operand;
      default:   new_value = old_value | operand;
    endcase
  end

  assign suppress  = (op != CSR_OP_RW) && (operand == '0);
  assign read_only = (address_top == 2'b11);
  assign write     = !suppress && !read_only;
  assign illegal   = !suppress && read_only;
endmodule

// File: rtl/csr_sequencer.sv
// Arbitrates CSR instructions, trap entry and MRET onto the single CSR-file
// port; trap/MRET run fixed multi-cycle sequences ending in a PC redirect.
module csr_sequencer
  import csr_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input logic            clk,
  input logic            reset_n,
  csr_sequencer_if.slave bus
);
  state_t                state;
  csr_op_t               op_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  interrupt_q;
  logic [DATA_WIDTH-2:0] cause_q;

  logic [DATA_WIDTH-1:0] alu_value;
  logic                  alu_write;
  logic                  alu_illegal;
  logic [DATA_WIDTH-1:0] mstatus_trap;
  logic [DATA_WIDTH-1:0] mstatus_mret;
  logic [DATA_WIDTH-1:0] write_value;
  logic                  write_enable;

  csr_rmw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op          (op_q),
    .address_top (bus.file_address[ADDRESS_WIDTH-1 -: 2]),
    .old_value   (bus.file_read_value),
    .operand     (operand_q),
    .new_value   (alu_value),
    .write       (alu_write),
    .illegal     (alu_illegal)
  );

  assign bus.req_ready = (state == ST_IDLE);

  always_comb begin
    mstatus_trap               = bus.file_read_value;
    mstatus_trap[MSTATUS_MPIE] = bus.file_read_value[MSTATUS_MIE];
    mstatus_trap[MSTATUS_MIE]  = 1'b0;
    mstatus_mret               = bus.file_read_value;
    mstatus_mret[MSTATUS_MIE]  = bus.file_read_value[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE] = 1'b1;
  end

  // Write data depends on the same-cycle file read, so the strobe and data
  // are decoded from the registered state rather than registered themselves.
  always_comb begin
    write_enable = 1'b0;
    write_value  = '0;
    case (state)
      ST_CSR_RMW: begin
        write_enable = alu_write;
        write_value  = alu_value;
      end
      ST_TRAP_MEPC: begin
        write_enable = 1'b1;
        write_value  = pc_q;
      end
      ST_TRAP_MCAUSE: begin
        write_enable = 1'b1;
        write_value  = {interrupt_q, cause_q};
      end
      ST_TRAP_MSTATUS: begin
        write_enable = 1'b1;
        write_value  = mstatus_trap;
      end
      ST_MRET_MSTATUS: begin
        write_enable = 1'b1;
        write_value  = mstatus_mret;
      end
      default: ;
    endcase
  end

  // Reset held mid-sequence must block the pending write at the reset edge.
  assign bus.file_write_enable = write_enable & reset_n;
  assign bus.file_write_value  = write_value;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      bus.csr_resp_valid <= 1'b0;
      bus.csr_illegal    <= 1'b0;
      bus.csr_rd_value   <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.file_address   <= '0;
      op_q               <= CSR_OP_NONE;
      operand_q          <= '0;
      pc_q               <= '0;
      interrupt_q        <= 1'b0;
      cause_q            <= '0;
    end else begin
      bus.csr_resp_valid <= 1'b0;
      bus.csr_illegal    <= 1'b0;
      bus.redirect_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.trap_valid) begin
            pc_q             <= align_pc(bus.trap_pc);
            interrupt_q      <= bus.trap_interrupt;
            cause_q          <= bus.trap_cause;
            bus.file_address <= CSR_MEPC;
            state            <= ST_TRAP_MEPC;
          end else if (bus.mret_valid) begin
            bus.file_address <= CSR_MSTATUS;
            state            <= ST_MRET_MSTATUS;
          end else if (bus.csr_valid) begin
            op_q             <= csr_op_t'(bus.csr_op);
            operand_q        <= bus.csr_operand;
            bus.file_address <= bus.csr_address;
            state            <= ST_CSR_RMW;
          end
        end
        ST_CSR_RMW: begin
          bus.csr_rd_value   <= bus.file_read_value;
          bus.csr_resp_valid <= 1'b1;
          bus.csr_illegal    <= alu_illegal;
          state              <= ST_IDLE;
        end
        ST_TRAP_MEPC: begin
          bus.file_address <= CSR_MCAUSE;
          state            <= ST_TRAP_MCAUSE;
        end
        ST_TRAP_MCAUSE: begin
          bus.file_address <= CSR_MSTATUS;
          state            <= ST_TRAP_MSTATUS;
        end
        ST_TRAP_MSTATUS: begin
          bus.file_address <= CSR_MTVEC;
          state            <= ST_TRAP_VECTOR;
        end
        ST_MRET_MSTATUS: begin
          bus.file_address <= CSR_MEPC;
          state            <= ST_MRET_EPC;
        end
        ST_TRAP_VECTOR, ST_MRET_EPC: begin
          bus.redirect_valid <= 1'b1;
          bus.redirect_pc    <= align_pc(bus.file_read_value);
          state              <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_sequencer.sv
// Scoreboard bench for csr_sequencer: a CSR-file model drives the issue-time
// reference; a negedge monitor checks writes, responses and redirects.
module tb_csr_sequencer;
  import csr_pkg::*;

  typedef struct { logic [11:0] addr; logic [31:0] data; int unsigned due; } wr_t;
  typedef struct { logic [31:0] data; logic illegal; int unsigned due; } resp_t;
  typedef struct { logic [31:0] pc; int unsigned due; } redir_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned cycle = 0;
  int          errors = 0;
  int          checks = 0;

  wr_t    wr_q[$];
  resp_t  resp_q[$];
  redir_t redir_q[$];
  logic [31:0] model [logic [11:0]];
  logic [31:0] file_mem [0:4095];
  logic [11:0] addrs [8];

  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  csr_sequencer_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) bus ();

  csr_sequencer #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // CSR file: combinational read, write at the edge
  assign bus.file_read_value = file_mem[bus.file_address];
  always @(posedge clk) begin
    if (bus.file_write_enable) file_mem[bus.file_address] <= bus.file_write_value;
    else if (poke_en)          file_mem[poke_addr] <= poke_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  always @(negedge clk) begin : monitor
    resp_t  r;
    redir_t d;
    wr_t    w;
    if (bus.csr_resp_valid || bus.redirect_valid)
      check("single_pulse", 64'(bus.csr_resp_valid & bus.redirect_valid), 64'(0));
    if (bus.csr_resp_valid) begin
      if (resp_q.size() == 0) fail("resp_unexpected");
      else begin
        r = resp_q.pop_front();
        check("resp_cycle", 64'(cycle), 64'(r.due));
        check("rd_value", 64'(bus.csr_rd_value), 64'(r.data));
        check("illegal", 64'(bus.csr_illegal), 64'(r.illegal));
      end
    end
    if (bus.redirect_valid) begin
      if (redir_q.size() == 0) fail("redirect_unexpected");
      else begin
        d = redir_q.pop_front();
        check("redirect_cycle", 64'(cycle), 64'(d.due));
        check("redirect_pc", 64'(bus.redirect_pc), 64'(d.pc));
      end
    end
    if (bus.file_write_enable) begin
      if (wr_q.size() == 0) fail("write_unexpected");
      else begin
        w = wr_q.pop_front();
        check("write_cycle", 64'(cycle), 64'(w.due));
        check("write_addr", 64'(bus.file_address), 64'(w.addr));
        check("write_data", 64'(bus.file_write_value), 64'(w.data));
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst_resp_valid", 64'(bus.csr_resp_valid), 64'(0));
    check("rst_redirect_valid", 64'(bus.redirect_valid), 64'(0));
    check("rst_rd_value", 64'(bus.csr_rd_value), 64'(0));
    check("rst_redirect_pc", 64'(bus.redirect_pc), 64'(0));
    check("rst_write_enable", 64'(bus.file_write_enable), 64'(0));
    check("rst_file_address", 64'(bus.file_address), 64'(0));
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] v);
    poke_addr = a;
    poke_data = v;
    poke_en   = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    model[a] = v;
  endtask

  // Reference rules: RW replaces, RS sets, RC clears; op 00 behaves as RS.
  task automatic model_csr(input int unsigned acc);
    logic [11:0] a = bus.csr_address;
    logic [31:0] opnd = bus.csr_operand;
    logic [31:0] old = model[a];
    logic [31:0] nv;
    logic        wants_write;
    logic        ill;
    if (bus.csr_op == 2'b01)      nv = opnd;
    else if (bus.csr_op == 2'b11) nv = old & ~opnd;
    else                          nv = old | opnd;
    wants_write = (bus.csr_op == 2'b01) || (opnd != 0);
    ill = wants_write && (a >= 12'hC00);
    if (wants_write && !ill) begin
      wr_q.push_back('{a, nv, acc});
      model[a] = nv;
    end
    resp_q.push_back('{old, ill, acc + 1});
  endtask

  task automatic model_trap(input int unsigned acc, input bit abort);
    logic [31:0] mepc = bus.trap_pc & ~32'h3;
    logic [31:0] mcause = {bus.trap_interrupt, bus.trap_cause};
    logic [31:0] ms;
    wr_q.push_back('{CSR_MEPC, mepc, acc});
    model[CSR_MEPC] = mepc;
    if (!abort) begin
      wr_q.push_back('{CSR_MCAUSE, mcause, acc + 1});
      model[CSR_MCAUSE] = mcause;
      ms = model[CSR_MSTATUS];
      ms = (ms & ~32'h88) | ((ms & 32'h8) << 4);
      wr_q.push_back('{CSR_MSTATUS, ms, acc + 2});
      model[CSR_MSTATUS] = ms;
      redir_q.push_back('{model[CSR_MTVEC] & ~32'h3, acc + 4});
    end
  endtask

  task automatic model_mret(input int unsigned acc);
    logic [31:0] ms = model[CSR_MSTATUS];
    ms = (ms & ~32'h88) | ((ms & 32'h80) >> 4) | 32'h80;
    wr_q.push_back('{CSR_MSTATUS, ms, acc});
    model[CSR_MSTATUS] = ms;
    redir_q.push_back('{model[CSR_MEPC] & ~32'h3, acc + 2});
  endtask

  // Hold all raised valids until each is accepted, highest priority first.
  task automatic run_pending(input bit abort_trap);
    int unsigned waited = 0;
    logic        ready;
    while (bus.trap_valid || bus.mret_valid || bus.csr_valid) begin
      @(negedge clk);
      ready = bus.req_ready;
      @(posedge clk);
      #1;
      if (ready) begin
        waited = 0;
        if (bus.trap_valid) begin
          model_trap(cycle, abort_trap);
          bus.trap_valid = 1'b0;
        end else if (bus.mret_valid) begin
          model_mret(cycle);
          bus.mret_valid = 1'b0;
        end else begin
          model_csr(cycle);
          bus.csr_valid = 1'b0;
        end
      end else if (++waited > 50) begin
        fail("accept_timeout");
        bus.trap_valid = 1'b0;
        bus.mret_valid = 1'b0;
        bus.csr_valid  = 1'b0;
      end
    end
  endtask

  task automatic csr_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v);
    bus.csr_op      = op;
    bus.csr_address = a;
    bus.csr_operand = v;
    bus.csr_valid   = 1'b1;
  endtask

  task automatic trap_req(input logic intr, input logic [30:0] cause, input logic [31:0] pc);
    bus.trap_interrupt = intr;
    bus.trap_cause     = cause;
    bus.trap_pc        = pc;
    bus.trap_valid     = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned diffs;
    bus.csr_valid = 1'b0; bus.csr_op = '0; bus.csr_address = '0; bus.csr_operand = '0;
    bus.trap_valid = 1'b0; bus.trap_interrupt = 1'b0; bus.trap_cause = '0; bus.trap_pc = '0;
    bus.mret_valid = 1'b0;
    addrs = '{CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
              CSR_MHARTID, 12'hF11};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
    foreach (addrs[i]) poke(addrs[i], $urandom);

    poke(CSR_MSCRATCH, 32'hDEADBEEF);
    csr_req(2'b10, CSR_MSCRATCH, 32'h0);
    run_pending(1'b0);
    poke(CSR_MSCRATCH, 32'h12345678);
    csr_req(2'b11, CSR_MSCRATCH, 32'h0000FFFF);
    run_pending(1'b0);
    csr_req(2'b01, CSR_MHARTID, 32'h5);
    run_pending(1'b0);
    settle();
    check("mscratch_after_rc", 64'(file_mem[CSR_MSCRATCH]), 64'(32'h12340000));

    poke(CSR_MTVEC, 32'h00000100);
    poke(CSR_MSTATUS, 32'h00000008);
    trap_req(1'b0, 31'd11, 32'h80000103);
    run_pending(1'b0);
    settle();
    check("mstatus_after_trap", 64'(file_mem[CSR_MSTATUS]), 64'(32'h80));

    poke(CSR_MSTATUS, 32'h00000008);
    trap_req(1'b1, 31'd7, 32'h00002206);
    bus.mret_valid = 1'b1;
    csr_req(2'b10, CSR_MSTATUS, 32'h0);
    run_pending(1'b0);
    settle();
    check("mstatus_after_mret", 64'(file_mem[CSR_MSTATUS]), 64'(32'h88));

    trap_req(1'b0, 31'd2, 32'h00001234);
    run_pending(1'b1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
    settle();
    check("mepc_after_abort", 64'(file_mem[CSR_MEPC]), 64'(32'h00001234));

    for (int it = 0; it < 200; it++) begin
      int unsigned mask = $urandom_range(1, 7);
      if (mask[0]) csr_req(2'($urandom), addrs[$urandom_range(0, 7)],
                           ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      if (mask[1]) bus.mret_valid = 1'b1;
      if (mask[2]) trap_req(1'($urandom), 31'($urandom), $urandom);
      run_pending(1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    settle();
    check("pending_writes", 64'(wr_q.size()), 64'(0));
    check("pending_resps", 64'(resp_q.size()), 64'(0));
    check("pending_redirects", 64'(redir_q.size()), 64'(0));
    diffs = 0;
    foreach (addrs[i]) if (file_mem[addrs[i]] !== model[addrs[i]]) diffs++;
    check("final_csr_contents", 64'(diffs), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
